mmio_uart: RTL and testbench

- Memory-mapped serial transmitter attached to the CPU external bus (a, d, n_oe, n_we).
- Decodes a two-byte window and buffers CPU writes in a small TX FIFO.
- Shifts bytes out as 8N1 serial frames.
- Downstream consumer of CPU bus cycles; sits beside RAM/ROM on the shared data bus.

---
 rtl/mmio_uart.sv | 269 ++++++++++++++++++++++++++
 tb/tb_mmio_uart.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO on the CPU external bus.
// Define MMIO_UART_RX_EN to add the rx input, an 8N1 receiver and a one-byte holding register.
//   state | meaning
//   IDLE  | line high, waiting for a queued byte
//   START | start bit (tx=0)
//   DATA  | eight data bits, LSB first
//   STOP  | stop bit (tx=1); may chain straight into the next START
module mmio_uart #(
  parameter logic [15:0] BASE_ADDR  = 16'hFF00,
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        n_rst,
`ifdef MMIO_UART_RX_EN
  input  logic        rx,
`endif
  input  logic [15:0] a,
  inout  wire  [7:0]  d,
  input  logic        n_oe,
  input  logic        n_we,
  output logic        tx,
  output logic        irq
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [3:0]  DEPTH_C = 4'(FIFO_DEPTH);
  localparam logic [15:0] DIV_LD  = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  logic          sel_data, sel_stat;
  logic          we_q, wr_stb, wr_data, wr_stat;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [3:0]    cnt;
  logic          full, push, pop, overflow, tx_idle;
  tx_state_t     state_q, state_d;
  logic [15:0]   div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_d;
  logic          rx_valid, rx_overrun;
  logic [7:0]    rx_byte;
  logic [7:0]    stat, rd_data;
  logic          rd_en;

  assign sel_data = (a == BASE_ADDR);
  assign sel_stat = (a == BASE_ADDR + 16'd1);

  // One commit per strobe: only the first edge that sees n_we low counts.
  assign wr_stb  = ~n_we & we_q;
  assign wr_data = wr_stb & sel_data;
  assign wr_stat = wr_stb & sel_stat;

  assign full    = (cnt == DEPTH_C);
  assign push    = wr_data & (~full | pop);
  assign tx_idle = (cnt == 4'd0) && (state_q == IDLE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) we_q <= 1'b1;
    else        we_q <= n_we;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wp       <= '0;
      rp       <= '0;
      cnt      <= 4'd0;
      overflow <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 4'd1;
        2'b01:   cnt <= cnt - 4'd1;
        default: cnt <= cnt;
      endcase
      if (wr_stat)                     overflow <= 1'b0;
      else if (wr_data & full & ~pop)  overflow <= 1'b1;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by cnt.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= d;
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cnt != 4'd0) begin
          pop     = 1'b1;
          sh_d    = mem[rp];
          div_d   = DIV_LD;
          state_d = START;
        end
      end
      START: begin
        if (div_q == 16'd0) begin
          div_d   = DIV_LD;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          div_d = div_q - 16'd1;
        end
      end
      DATA: begin
        if (div_q == 16'd0) begin
          div_d = DIV_LD;
          sh_d  = {1'b1, sh_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          div_d = div_q - 16'd1;
        end
      end
      STOP: begin
        // Chain directly into the next frame so there is no idle gap.
        if (div_q == 16'd0) begin
          if (cnt != 4'd0) begin
            pop     = 1'b1;
            sh_d    = mem[rp];
            div_d   = DIV_LD;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          div_d = div_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    if (state_d == START)     tx_d = 1'b0;
    else if (state_d == DATA) tx_d = sh_d[0];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      div_q   <= 16'd0;
      bit_q   <= 3'd0;
      sh_q    <= 8'h00;
      tx      <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx      <= tx_d;
    end
  end

`ifdef MMIO_UART_RX_EN
  localparam logic [15:0] HALF_LD = 16'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  logic        rx_s1, rx_s2, rx_prev, oe_q, rx_done;
  rx_state_t   rxs_q, rxs_d;
  logic [15:0] rdiv_q, rdiv_d;
  logic [2:0]  rbit_q, rbit_d;
  logic [7:0]  rsh_q, rsh_d;

  always_comb begin
    rxs_d   = rxs_q;
    rdiv_d  = rdiv_q;
    rbit_d  = rbit_q;
    rsh_d   = rsh_q;
    rx_done = 1'b0;
    case (rxs_q)
      R_IDLE: begin
        if (rx_prev & ~rx_s2) begin
          rdiv_d = HALF_LD;
          rxs_d  = R_START;
        end
      end
      R_START: begin
        if (rdiv_q == 16'd0) begin
          if (!rx_s2) begin
            rdiv_d = DIV_LD;
            rbit_d = 3'd0;
            rxs_d  = R_DATA;
          end else begin
            rxs_d = R_IDLE;
          end
        end else begin
          rdiv_d = rdiv_q - 16'd1;
        end
      end
      R_DATA: begin
        if (rdiv_q == 16'd0) begin
          rdiv_d = DIV_LD;
          rsh_d  = {rx_s2, rsh_q[7:1]};
          if (rbit_q == 3'd7) rxs_d  = R_STOP;
          else                rbit_d = rbit_q + 3'd1;
        end else begin
          rdiv_d = rdiv_q - 16'd1;
        end
      end
      R_STOP: begin
        if (rdiv_q == 16'd0) begin
          rx_done = rx_s2;
          rxs_d   = R_IDLE;
        end else begin
          rdiv_d = rdiv_q - 16'd1;
        end
      end
      default: rxs_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      oe_q       <= 1'b1;
      rxs_q      <= R_IDLE;
      rdiv_q     <= 16'd0;
      rbit_q     <= 3'd0;
      rsh_q      <= 8'h00;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      rx_byte    <= 8'h00;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      oe_q    <= n_oe;
      rxs_q   <= rxs_d;
      rdiv_q  <= rdiv_d;
      rbit_q  <= rbit_d;
      rsh_q   <= rsh_d;
      if (rx_done) begin
        rx_byte  <= rsh_q;
        rx_valid <= 1'b1;
      end else if (n_oe & ~oe_q & sel_data) begin
        rx_valid <= 1'b0;
      end
      if (rx_done & rx_valid) rx_overrun <= 1'b1;
      else if (wr_stat)       rx_overrun <= 1'b0;
    end
  end

  assign irq = tx_idle | rx_valid;
`else
  assign rx_valid   = 1'b0;
  assign rx_overrun = 1'b0;
  assign rx_byte    = 8'h00;
  assign irq        = tx_idle;
`endif

  assign stat    = {rx_overrun, cnt[2:0], rx_valid, overflow, tx_idle, full};
  assign rd_data = sel_data ? rx_byte : stat;
  assign rd_en   = ~n_oe & n_we & (sel_data | sel_stat);
  assign d       = rd_en ? rd_data : 8'bz;

endmodule

// File: tb/tb_mmio_uart.sv
// Scoreboard bench for mmio_uart: bus reads and serial frames are checked by
// monitors against expectations queued by the stimulus.
module tb_mmio_uart;

  localparam int         CLK_DIV    = 16;
  localparam int         FIFO_DEPTH = 4;
  localparam logic [7:0] HIZ        = 8'hFF;  // undriven bus reads through the pull-ups

  typedef struct {
    string      name;
    logic [7:0] exp;
    logic       eirq;
  } rd_exp_t;

  logic        clk;
  logic        n_rst;
  logic [15:0] a;
  logic        n_oe;
  logic        n_we;
  logic        tx;
  logic        irq;
  wire  [7:0]  d;
  logic [7:0]  d_tb;
  logic        d_en;
  logic        rd_probe;
  logic        mon_en;
  logic [7:0]  mon_got;
  logic [7:0]  mon_want;
  rd_exp_t     rd_e;

  rd_exp_t     rd_q[$];
  logic [7:0]  tx_q[$];
  int          errors = 0;
  int          checks = 0;

  assign d = d_en ? d_tb : 8'bz;
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (d[i]);
  end

  mmio_uart #(
    .BASE_ADDR (16'hFF00),
    .CLK_DIV   (CLK_DIV),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .a    (a),
    .d    (d),
    .n_oe (n_oe),
    .n_we (n_we),
    .tx   (tx),
    .irq  (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [7:0] data, input int len);
    @(negedge clk);
    a    = addr;
    d_tb = data;
    d_en = 1'b1;
    n_we = 1'b0;
    repeat (len) @(negedge clk);
    n_we = 1'b1;
    d_en = 1'b0;
  endtask

  task automatic probe(input string name, input logic [15:0] addr, input logic noe,
                       input logic nwe, input logic [7:0] exp, input logic eirq);
    rd_exp_t e;
    e.name = name;
    e.exp  = exp;
    e.eirq = eirq;
    @(negedge clk);
    a    = addr;
    n_oe = noe;
    n_we = nwe;
    rd_q.push_back(e);
    rd_probe = 1'b1;
    @(negedge clk);
    rd_probe = 1'b0;
    n_oe     = 1'b1;
    n_we     = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int maxc);
    int n;
    n = 0;
    while (irq !== 1'b1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, irq}, 32'd1);
  endtask

  // Bus read monitor
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rd_probe) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected: got %h expected none", d);
        end else begin
          rd_e = rd_q.pop_front();
          chk(rd_e.name, {24'd0, d}, {24'd0, rd_e.exp});
          chk({rd_e.name, "_irq"}, {31'd0, irq}, {31'd0, rd_e.eirq});
        end
      end
    end
  end

  // Serial frame monitor: mid-bit sampling from the falling start edge
  initial begin
    forever begin
      @(negedge tx);
      if (mon_en) begin
        repeat (CLK_DIV / 2) @(posedge clk);
        #1;
        chk("start_bit", {31'd0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(posedge clk);
          #1;
          mon_got[i] = tx;
        end
        repeat (CLK_DIV) @(posedge clk);
        #1;
        chk("stop_bit", {31'd0, tx}, 32'd1);
        if (tx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_unexpected: got %h expected none", mon_got);
        end else begin
          mon_want = tx_q.pop_front();
          chk("frame_byte", {24'd0, mon_got}, {24'd0, mon_want});
        end
      end
    end
  end

  initial begin
    int n;
    n_rst    = 1'b0;
    a        = 16'h0000;
    n_oe     = 1'b1;
    n_we     = 1'b1;
    d_tb     = 8'h00;
    d_en     = 1'b0;
    rd_probe = 1'b0;
    mon_en   = 1'b0;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;

    probe("reset_status", 16'hFF01, 1'b0, 1'b1, 8'h02, 1'b1);
    probe("reset_ff02_hiz", 16'hFF02, 1'b0, 1'b1, HIZ, 1'b1);

    // Abort a frame with an asynchronous reset during its start bit
    bus_write(16'hFF00, 8'h5A, 1);
    repeat (8) @(negedge clk);
    chk("tx_start_before_reset", {31'd0, tx}, 32'd0);
    #2 n_rst = 1'b0;
    #1;
    chk("tx_async_reset", {31'd0, tx}, 32'd1);
    chk("irq_async_reset", {31'd0, irq}, 32'd1);
    probe("status_in_reset", 16'hFF01, 1'b0, 1'b1, 8'h02, 1'b1);
    @(negedge clk);
    n_rst  = 1'b1;
    mon_en = 1'b1;

    // Single frame: irq returns 160 cycles after the start bit begins
    tx_q.push_back(8'hA5);
    bus_write(16'hFF00, 8'hA5, 1);
    n = 0;
    @(negedge clk);
    while (irq !== 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("frame_cycles", n, 32'd160);
    probe("status_after_a5", 16'hFF01, 1'b0, 1'b1, 8'h02, 1'b1);

    // Burst of five: first is popped at once, the rest fill the FIFO
    foreach (tx_q[i]) n = n;
    begin
      logic [7:0] burst [5];
      burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      for (int i = 0; i < 5; i++) begin
        tx_q.push_back(burst[i]);
        bus_write(16'hFF00, burst[i], 1);
      end
    end
    probe("status_full", 16'hFF01, 1'b0, 1'b1, 8'h41, 1'b0);
    bus_write(16'hFF00, 8'h66, 1);
    probe("status_overflow", 16'hFF01, 1'b0, 1'b1, 8'h45, 1'b0);
    bus_write(16'hFF01, 8'hFF, 1);
    probe("status_ovf_cleared", 16'hFF01, 1'b0, 1'b1, 8'h41, 1'b0);
    wait_idle("burst_drained", 3000);

    // Long write strobe while busy queues exactly one byte
    tx_q.push_back(8'h81);
    bus_write(16'hFF00, 8'h81, 1);
    tx_q.push_back(8'h77);
    bus_write(16'hFF00, 8'h77, 10);
    probe("status_long_strobe", 16'hFF01, 1'b0, 1'b1, 8'h10, 1'b0);
    wait_idle("long_strobe_drained", 1000);

    // Bus ownership
    probe("drive_stat", 16'hFF01, 1'b0, 1'b1, 8'h02, 1'b1);
    probe("hiz_other_addr", 16'hFF02, 1'b0, 1'b1, HIZ, 1'b1);
    probe("hiz_noe_high", 16'hFF01, 1'b1, 1'b1, HIZ, 1'b1);
    probe("hiz_during_we", 16'hFF01, 1'b0, 1'b0, HIZ, 1'b1);
    probe("data_reg_zero", 16'hFF00, 1'b0, 1'b1, 8'h00, 1'b1);

    repeat (4 * CLK_DIV) @(negedge clk);
    chk("tx_q_empty", tx_q.size(), 32'd0);
    chk("rd_q_empty", rd_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
